// File: rtl/scim_sc_accumulator.sv
// scim_sc_accumulator
// Sequences one stochastic run of the SC compute macro. It holds COMP_EN/RN_ADV
// high for LEN cycles, then waits for the macro latency to drain. It keeps a
// signed up/down count per macro output channel: P counts +1 and N counts -1.
// The final counts are handed off with a valid/ready handshake.

module scim_sc_accumulator #(
  parameter int N_S       = 32,
  parameter int N_C       = 32,
  parameter int BSL_W     = 8,
  parameter int CNT_W     = BSL_W + 1,
  parameter int MACRO_LAT = 2
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         START,
  input  logic [BSL_W-1:0]             LEN,
  output logic                         BUSY,
  output logic                         COMP_EN,
  output logic                         RN_ADV,
  input  logic [N_S*N_C-1:0]           DOUTP,
  input  logic [N_S*N_C-1:0]           DOUTN,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [N_S*N_C*CNT_W-1:0]     ACC
);

  localparam int N_OUT = N_S * N_C;
  localparam logic signed [CNT_W-1:0] CNT_MAX = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic signed [CNT_W-1:0] CNT_MIN = -CNT_MAX;
  localparam logic [BSL_W-1:0] DRAIN_LEN = BSL_W'(MACRO_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [BSL_W-1:0]        rem;
  logic [MACRO_LAT-1:0]    pipe;
  logic                    sample;
  logic                    start_run;
  logic signed [CNT_W-1:0] acc_q [N_OUT];

  assign start_run = (state == S_IDLE) && START;
  assign sample    = pipe[MACRO_LAT-1];
  assign RN_ADV    = COMP_EN;

  // State register; reset always returns to IDLE, so a partial run is never flagged valid
  always_ff @(posedge CLK) begin
    if (!RESETN) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state and Moore outputs; START is only looked at in IDLE, and a zero-length run goes straight to DONE
  always_comb begin
    next_state = state;
    BUSY       = 1'b1;
    COMP_EN    = 1'b0;
    OUT_VALID  = 1'b0;
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) next_state = (LEN == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        COMP_EN = 1'b1;
        if (rem == BSL_W'(1)) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (rem == BSL_W'(1)) next_state = S_DONE;
      end
      S_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Remaining-cycle counter; it counts the run length first and is then reloaded with the drain length
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      rem <= '0;
    end else begin
      case (state)
        S_IDLE:  if (START) rem <= LEN;
        S_RUN:   rem <= (rem == BSL_W'(1)) ? DRAIN_LEN : rem - BSL_W'(1);
        S_DRAIN: rem <= rem - BSL_W'(1);
        default: rem <= rem;
      endcase
    end
  end

  // Delay line of COMP_EN matching the macro latency; its output marks the edges where DOUT is valid
  always_ff @(posedge CLK) begin
    if (!RESETN) pipe <= '0;
    else         pipe <= (pipe << 1) | MACRO_LAT'(COMP_EN);
  end

  // Per-channel saturating up/down counters; cleared on reset and on an accepted START, held otherwise
  always_ff @(posedge CLK) begin
    if (!RESETN || start_run) begin
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
    end else if (sample) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (DOUTP[k] && !DOUTN[k]) begin
          if (acc_q[k] != CNT_MAX) acc_q[k] <= acc_q[k] + CNT_W'(1);
        end else if (!DOUTP[k] && DOUTN[k]) begin
          if (acc_q[k] != CNT_MIN) acc_q[k] <= acc_q[k] - CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_flat
    assign ACC[g*CNT_W +: CNT_W] = acc_q[g];
  end

endmodule
